// File: rtl/alu_decode_stage.sv
// ALU-side decode and ID/EX register: ALU control, operands and writeback tags.
// Optional ALU_DECODE_ILLEGAL_EN adds a registered IllegalE flag.
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] InstrD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic        ValidD,
    input  logic        StallE,
    input  logic        FlushE,
    output logic [3:0]  ALUCtrlE,
    output logic [31:0] SrcAE,
    output logic [31:0] SrcBE,
    output logic [4:0]  DstRegE,
    output logic        RegWriteE,
    output logic        ValidE
`ifdef ALU_DECODE_ILLEGAL_EN
    ,
    output logic        IllegalE
`endif
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] se;
    logic [31:0] ze;

    assign op    = InstrD[31:26];
    assign funct = InstrD[5:0];
    assign rt    = InstrD[20:16];
    assign rd    = InstrD[15:11];
    assign se    = {{16{InstrD[15]}}, InstrD[15:0]};
    assign ze    = {16'h0, InstrD[15:0]};

    logic [3:0]  dec_alu;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_dst;
    logic        dec_we;
    logic        dec_ill;

    // Unsupported encodings fall through to the register-operand defaults.
    always_comb begin
        dec_alu = 4'b0000;
        dec_a   = RD1D;
        dec_b   = RD2D;
        dec_dst = 5'd0;
        dec_we  = 1'b0;
        dec_ill = 1'b0;
        if (InstrD == 32'h0) begin
            dec_a = 32'h0;
            dec_b = 32'h0;
        end else begin
            unique case (op)
                6'h00: begin
                    dec_dst = rd;
                    dec_we  = 1'b1;
                    unique case (funct)
                        6'h24:        dec_alu = 4'b0000;
                        6'h25:        dec_alu = 4'b0001;
                        6'h20, 6'h21: dec_alu = 4'b0010;
                        6'h2A, 6'h2B: dec_alu = 4'b0011;
                        6'h26:        dec_alu = 4'b0100;
                        6'h27:        dec_alu = 4'b0101;
                        6'h22, 6'h23: dec_alu = 4'b0110;
                        default: begin
                            dec_dst = 5'd0;
                            dec_we  = 1'b0;
                            dec_ill = 1'b1;
                        end
                    endcase
                end
                6'h08, 6'h09, 6'h0A, 6'h0B: begin
                    dec_alu = op[1] ? 4'b0011 : 4'b0010;
                    dec_b   = se;
                    dec_dst = rt;
                    dec_we  = 1'b1;
                end
                6'h0C, 6'h0D, 6'h0E: begin
                    dec_alu = {1'b0, op[1], 1'b0, op[0]};
                    dec_b   = ze;
                    dec_dst = rt;
                    dec_we  = 1'b1;
                end
                6'h0F: begin
                    dec_alu = 4'b0111;
                    dec_a   = {InstrD[15:0], 16'h0};
                    dec_b   = 32'h0;
                    dec_dst = rt;
                    dec_we  = 1'b1;
                end
                6'h23: begin
                    dec_alu = 4'b0010;
                    dec_b   = se;
                    dec_dst = rt;
                    dec_we  = 1'b1;
                end
                6'h2B: begin
                    dec_alu = 4'b0010;
                    dec_b   = se;
                end
                6'h04, 6'h05: begin
                    dec_alu = 4'b0110;
                end
                default: dec_ill = 1'b1;
            endcase
        end
    end

    logic [3:0]  alu_d,   alu_q;
    logic [31:0] srca_d,  srca_q;
    logic [31:0] srcb_d,  srcb_q;
    logic [4:0]  dst_d,   dst_q;
    logic        we_d,    we_q;
    logic        valid_d, valid_q;
    logic        load;

    // Flush beats stall; an invalid slot loads the same bubble as a flush.
    assign load = !FlushE && !StallE && ValidD;

    always_comb begin
        alu_d   = alu_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        dst_d   = dst_q;
        we_d    = we_q;
        valid_d = valid_q;
        if (FlushE || !StallE) begin
            alu_d   = load ? dec_alu : 4'b0000;
            srca_d  = load ? dec_a   : 32'h0;
            srcb_d  = load ? dec_b   : 32'h0;
            dst_d   = load ? dec_dst : 5'd0;
            we_d    = load ? dec_we  : 1'b0;
            valid_d = load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q   <= 4'b0000;
            srca_q  <= 32'h0;
            srcb_q  <= 32'h0;
            dst_q   <= 5'd0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            dst_q   <= dst_d;
            we_q    <= we_d;
            valid_q <= valid_d;
        end
    end

    assign ALUCtrlE  = alu_q;
    assign SrcAE     = srca_q;
    assign SrcBE     = srcb_q;
    assign DstRegE   = dst_q;
    assign RegWriteE = we_q;
    assign ValidE    = valid_q;

`ifdef ALU_DECODE_ILLEGAL_EN
    logic ill_d, ill_q;

    always_comb begin
        ill_d = ill_q;
        if (FlushE || !StallE) begin
            ill_d = load && dec_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end

    assign IllegalE = ill_q;
`else
    logic unused_ill;
    assign unused_ill = dec_ill;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage; expected ID/EX contents are queued
// as stimulus is driven and compared one cycle later.
module tb_alu_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] InstrD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic        ValidD;
    logic        StallE;
    logic        FlushE;
    logic [3:0]  ALUCtrlE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [4:0]  DstRegE;
    logic        RegWriteE;
    logic        ValidE;
    logic        ill_obs;

    int tests;
    int fails;

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        we;
        logic        valid;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    alu_decode_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .InstrD(InstrD),
        .RD1D(RD1D),
        .RD2D(RD2D),
        .ValidD(ValidD),
        .StallE(StallE),
        .FlushE(FlushE),
        .ALUCtrlE(ALUCtrlE),
        .SrcAE(SrcAE),
        .SrcBE(SrcBE),
        .DstRegE(DstRegE),
        .RegWriteE(RegWriteE),
        .ValidE(ValidE)
`ifdef ALU_DECODE_ILLEGAL_EN
        ,
        .IllegalE(ill_obs)
`endif
    );

`ifndef ALU_DECODE_ILLEGAL_EN
    assign ill_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] alu, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] dst,
                                input logic we, input logic valid,
                                input logic ill);
        exp_t e;
        e.alu = alu; e.a = a; e.b = b; e.dst = dst;
        e.we = we; e.valid = valid; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t obs();
        return mk(ALUCtrlE, SrcAE, SrcBE, DstRegE, RegWriteE, ValidE, ill_obs);
    endfunction

    localparam exp_t ZERO = '0;
`ifdef ALU_DECODE_ILLEGAL_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    task automatic drive(input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic v,
                         input logic s, input logic f);
        InstrD = i; RD1D = a; RD2D = b;
        ValidD = v; StallE = s; FlushE = f;
    endtask

    task automatic test_reset();
        exp_t o;
        rst_n = 1'b0;
        drive(32'h014B4820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        o = obs();
        tests++;
        if (o !== ZERO) begin
            $display("FAIL reset: got %h want %h", o, ZERO);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        exp_t o, e;
        drive(32'h014B4820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0010, 32'd5, 32'd7, 5'd9, 1'b1, 1'b1, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL add: got %h want %h", o, e);
            fails++;
        end
    endtask

    task automatic test_imm_ext();
        exp_t o, e;
        drive(32'h30228001, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0000, 32'hFFFFFFFF, 32'h00008001, 5'd2, 1'b1, 1'b1, 1'b0));
        @(posedge clk); #1;
        drive(32'h20228001, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0010, 32'hFFFFFFFF, 32'hFFFF8001, 5'd2, 1'b1, 1'b1, 1'b0));
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL andi_ze: got %h want %h", o, e);
            fails++;
        end
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL addi_se: got %h want %h", o, e);
            fails++;
        end
    endtask

    task automatic test_lui();
        exp_t o, e;
        drive(32'h3C031234, 32'hDEADBEEF, 32'h55AA55AA, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0111, 32'h12340000, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL lui: got %h want %h", o, e);
            fails++;
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn [10] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h2A,
                                6'h2B, 6'h26, 6'h27, 6'h22, 6'h23};
        logic [3:0] cd [10] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3,
                                4'd3, 4'd4, 4'd5, 4'd6, 4'd6};
        exp_t o, e;
        for (int k = 0; k < 10; k++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            drive({6'h00, 5'd4, 5'd5, 5'd6, 5'd0, fn[k]}, a, b, 1'b1, 1'b0, 1'b0);
            sb.push_back(mk(cd[k], a, b, 5'd6, 1'b1, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs();
            tests++;
            if (o !== e) begin
                $display("FAIL rtype_%h: got %h want %h", fn[k], o, e);
                fails++;
            end
        end
    endtask

    task automatic test_itype();
        logic [5:0] opc [6] = '{6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h09, 6'h23};
        logic [3:0] cd  [6] = '{4'd1, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2};
        logic       sx  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_t o, e;
        for (int k = 0; k < 6; k++) begin
            logic [15:0] imm;
            logic [31:0] ext;
            imm = (k % 2 == 0) ? 16'hF00D : 16'h0123;
            ext = (sx[k] && imm[15]) ? {16'hFFFF, imm} : {16'h0000, imm};
            drive({opc[k], 5'd7, 5'd8, imm}, 32'h11112222, 32'h3, 1'b1, 1'b0, 1'b0);
            sb.push_back(mk(cd[k], 32'h11112222, ext, 5'd8, 1'b1, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs();
            tests++;
            if (o !== e) begin
                $display("FAIL itype_%h: got %h want %h", opc[k], o, e);
                fails++;
            end
        end
    endtask

    task automatic test_store_branch();
        logic [31:0] ins [3] = '{32'hAC220004, 32'h10220010, 32'h14220010};
        logic [3:0]  cd  [3] = '{4'b0010, 4'b0110, 4'b0110};
        logic [31:0] bb  [3] = '{32'h4, 32'h77, 32'h77};
        exp_t o, e, m;
        m = '1;
        m.dst = 5'd0;
        for (int k = 0; k < 3; k++) begin
            drive(ins[k], 32'h100, 32'h77, 1'b1, 1'b0, 1'b0);
            sb.push_back(mk(cd[k], 32'h100, bb[k], 5'd0, 1'b0, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs();
            tests++;
            if ((o & m) !== (e & m)) begin
                $display("FAIL st_br_%0d: got %h want %h", k, o & m, e & m);
                fails++;
            end
        end
    endtask

    task automatic test_stall();
        exp_t o, e;
        drive(32'h014B4820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0010, 32'd5, 32'd7, 5'd9, 1'b1, 1'b1, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL stall_load: got %h want %h", o, e);
            fails++;
        end
        for (int k = 0; k < 3; k++) begin
            drive(32'h3C030000 | k, 32'h9 + k, 32'h1, 1'b1, 1'b1, 1'b0);
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs();
            tests++;
            if (o !== e) begin
                $display("FAIL stall_hold%0d: got %h want %h", k, o, e);
                fails++;
            end
        end
        drive(32'h30228001, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0000, 32'hFFFFFFFF, 32'h00008001, 5'd2, 1'b1, 1'b1, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL stall_release: got %h want %h", o, e);
            fails++;
        end
    endtask

    task automatic test_flush_bubble();
        exp_t o, e;
        drive(32'h014B4820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(32'h014B4820, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
        sb.push_back(ZERO);
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL flush_stall: got %h want %h", o, e);
            fails++;
        end
        drive(32'h014B4820, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
        sb.push_back(ZERO);
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL invalid_bubble: got %h want %h", o, e);
            fails++;
        end
        drive(32'h0, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL nop: got %h want %h", o, e);
            fails++;
        end
    endtask

    task automatic test_illegal();
        exp_t o, e;
        drive(32'h00021900, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0000, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd0, 1'b0, 1'b1, ILL));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL sll_illegal: got %h want %h", o, e);
            fails++;
        end
        drive(32'hFC000000, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0000, 32'h1, 32'h2, 5'd0, 1'b0, 1'b1, ILL));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL op3f_illegal: got %h want %h", o, e);
            fails++;
        end
        drive(32'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        sb.push_back(mk(4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs();
        tests++;
        if (o !== e) begin
            $display("FAIL nop_legal: got %h want %h", o, e);
            fails++;
        end
    endtask

    task automatic test_async_reset();
        exp_t o;
        drive(32'h014B4820, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(32'h014B4820, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        o = obs();
        tests++;
        if (o !== ZERO) begin
            $display("FAIL async_reset: got %h want %h", o, ZERO);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        o = obs();
        tests++;
        if (o !== ZERO) begin
            $display("FAIL reset_discard: got %h want %h", o, ZERO);
            fails++;
        end
        StallE = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add();
        test_imm_ext();
        test_lui();
        test_rtype();
        test_itype();
        test_store_branch();
        test_stall();
        test_flush_bubble();
        test_illegal();
        test_async_reset();
        test_add();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode-side producer for the execute-stage ALU: turns the ID-stage instruction word and register-file read data into the `ALUCtrlE`, `SrcAE` and `SrcBE` operands the ALU consumes. It also produces the writeback controls that travel with them. All outputs come from the ID/EX pipeline register, which supports stall and flush, so this block is the single owner of ALU-side ID/EX state.

## Interface
- No parameters; data width is fixed at 32.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `InstrD`  in  32  ID-stage instruction word.
- `RD1D`  in  32  register-file read data for rs.
- `RD2D`  in  32  register-file read data for rt.
- `ValidD`  in  1  `InstrD` holds a real instruction this cycle.
- `StallE`  in  1  hold the ID/EX register contents.
- `FlushE`  in  1  load a bubble into the ID/EX register.
- `ALUCtrlE`  out  4  ALU operation code.
- `SrcAE`  out  32  ALU operand A.
- `SrcBE`  out  32  ALU operand B.
- `DstRegE`  out  5  destination register number.
- `RegWriteE`  out  1  result is written back.
- `ValidE`  out  1  EX stage holds a real instruction.
- `IllegalE`  out  1  unsupported encoding; present only with `ALU_DECODE_ILLEGAL_EN`.

## Operation
- Opcode is `InstrD[31:26]`, funct is `[5:0]`, rs is `[25:21]`, rt is `[20:16]`, rd is `[15:11]`, imm is `[15:0]`.
- **SE** is the 32-bit sign-extended imm. **ZE** is the 32-bit zero-extended imm.
- **R-type (opcode 0x00):** `SrcAE`=RD1D, `SrcBE`=RD2D, `DstRegE`=rd, `RegWriteE`=1. Funct decode:
  - 0x24 gives 0000 (and).
  - 0x25 gives 0001 (or).
  - 0x20 and 0x21 give 0010 (add).
  - 0x2A and 0x2B give 0011 (slt).
  - 0x26 gives 0100 (xor).
  - 0x27 gives 0101 (nor).
  - 0x22 and 0x23 give 0110 (sub).
- **I-type:** `SrcAE`=RD1D, `DstRegE`=rt, `RegWriteE`=1.
  - addi (0x08) and addiu (0x09): 0010, `SrcBE`=SE.
  - slti (0x0A) and sltiu (0x0B): 0011, `SrcBE`=SE.
  - andi (0x0C): 0000, `SrcBE`=ZE.
  - ori (0x0D): 0001, `SrcBE`=ZE.
  - xori (0x0E): 0100, `SrcBE`=ZE.
- **lui (0x0F):** 0111, `SrcAE`={imm,16'h0}, `SrcBE`=0, `DstRegE`=rt, `RegWriteE`=1.
- **lw (0x23):** 0010, `SrcBE`=SE, `RegWriteE`=1, `DstRegE`=rt.
- **sw (0x2B):** 0010, `SrcBE`=SE, `RegWriteE`=0.
- **beq (0x04) and bne (0x05):** 0110, `SrcBE`=RD2D, `RegWriteE`=0.
- **`InstrD`==32'h0 (nop):** legal. ALUCtrl 0000, operands 0, `RegWriteE`=0.
- **Any other encoding:** ALUCtrl 0000, `SrcAE`=RD1D, `SrcBE`=RD2D, `DstRegE`=0, `RegWriteE`=0.
- **`ValidD`=0:** the register loads a bubble.

## Timing
- Latency: exactly one cycle from `InstrD` to the E outputs.
- **Reset:** every output is 0, including `ValidE` and `IllegalE`. This takes effect immediately on `rst_n` low, independent of `clk`.
- **Priority per edge:** `FlushE` > `StallE` > load.
  - Flush writes an all-zero bubble; all outputs 0.
  - Stall holds every output bit unchanged.
  - Load captures the decode of the current inputs.
- **Flush together with stall:** the bubble is loaded.
- **Stall held N cycles:** outputs stay constant for N cycles. The first unstalled edge loads the `InstrD` present at that edge.
- **Reset asserted mid-stall:** outputs go to 0 and the held instruction is discarded.
- The decode path is purely combinational into the register; no output depends combinationally on any input.

## Configuration
- `ALU_DECODE_ILLEGAL_EN` defined:
  - The `IllegalE` port exists.
  - It is registered with the other outputs and follows the same reset, flush and stall rules.
  - It is 1 when a valid, non-nop instruction falls into the "any other encoding" class.
- `ALU_DECODE_ILLEGAL_EN` undefined:
  - The port and its register are absent.
  - Unsupported encodings decode silently as described above.

## Test plan
- Reset, then release and load add (`InstrD`=0x014B4820, RD1D=5, RD2D=7). Next cycle: ALUCtrlE=0010, SrcAE=5, SrcBE=7, DstRegE=9, RegWriteE=1, ValidE=1.
- Load andi with imm 0x8001 and RD1D=0xFFFFFFFF, then addi with imm 0x8001. Results: SrcBE=0x00008001 (ZE) for andi, then SrcBE=0xFFFF8001 (SE) for addi.
- Load lui with imm 0x1234. Result: ALUCtrlE=0111, SrcAE=0x12340000, SrcBE=0, RegWriteE=1.
- Load sw, then beq. Result: RegWriteE=0 for both; ALUCtrlE is 0010, then 0110.
- Load add, hold `StallE` for 3 cycles while `InstrD` changes. Outputs stay unchanged for 3 cycles.
- Assert `FlushE` and `StallE` together: all outputs go to 0.
- Pulse `rst_n` low mid-cycle: outputs clear before the next edge.
- With the macro defined, load funct 0x00 and shamt≠0 (sll): IllegalE=1, RegWriteE=0. Load 32'h0: IllegalE=0.
